// File: rtl/mem_pkg.sv
// Shared definitions for the load/store sequencer: size encodings, FSM states
// and big-endian lane selection helpers.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [31:0] LANE_MASK_BYTE = 32'h0000_00FF;
    localparam logic [31:0] LANE_MASK_HALF = 32'h0000_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RMW_RD,
        ST_WR,
        ST_DONE
    } state_t;

    // Right-shift that brings the addressed big-endian lane down to bit 0.
    function automatic logic [4:0] lane_shift(input logic [1:0] sz, input logic [1:0] off);
        if (sz == SZ_HALF)
            return {~off[1], 4'b0000};
        if (sz == SZ_BYTE)
            return {~off, 3'b000};
        return 5'd0;
    endfunction

endpackage

// File: rtl/mem_lane_extract.sv
// Selects the addressed byte/halfword lane of a memory word and
// sign- or zero-extends it to 32 bits; words pass through unchanged.
module mem_lane_extract
    import mem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_off,
    input  logic        i_sext,
    output logic [31:0] o_data
);

    logic [4:0]  w_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_shift = lane_shift(i_size, i_off);
        w_byte  = 8'(i_word >> w_shift);
        w_half  = 16'(i_word >> w_shift);
        case (i_size)
            SZ_BYTE: o_data = {{24{i_sext & w_byte[7]}}, w_byte};
            SZ_HALF: o_data = {{16{i_sext & w_half[15]}}, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer for a word-only big-endian data memory: aligns the
// address, extracts sub-word loads, does read-modify-write for sub-word stores.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 61
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        err,
    output logic        busy,
    output logic        mem_RD,
    output logic        mem_WR,
    output logic [31:0] mem_Daddr,
    output logic [31:0] mem_DataIn,
    input  logic [31:0] mem_DataOut
);

    state_t      r_state;
    logic [1:0]  r_size;
    logic [1:0]  r_off;
    logic        r_sext;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_done;
    logic        r_err;
    logic        r_busy;
    logic        r_rd_n;
    logic        r_wr_n;
    logic [31:0] r_daddr;
    logic [31:0] r_dout;

    logic [31:0] w_base;
    logic        w_misalign;
    logic        w_oor;
    logic        w_bad;
    logic [4:0]  w_shift;
    logic [31:0] w_mask;
    logic [31:0] w_merge;
    logic [31:0] w_ext;

    always_comb begin
        w_base     = {addr[31:2], 2'b00};
        w_misalign = (size == SZ_HALF && addr[0])
                   || (size == SZ_WORD && addr[1:0] != 2'b00)
                   || (size == 2'b11);
        w_oor      = ({1'b0, w_base} + 33'd3) > 33'(MEM_BYTES - 1);
        w_bad      = w_misalign | w_oor;
    end

    // Merge word for sub-word stores: memory word with the target lane(s) replaced.
    always_comb begin
        w_shift = lane_shift(r_size, r_off);
        w_mask  = ((r_size == SZ_BYTE) ? LANE_MASK_BYTE : LANE_MASK_HALF) << w_shift;
        w_merge = (mem_DataOut & ~w_mask) | ((r_wdata << w_shift) & w_mask);
    end

    mem_lane_extract u_extract (
        .i_word (mem_DataOut),
        .i_size (r_size),
        .i_off  (r_off),
        .i_sext (r_sext),
        .o_data (w_ext)
    );

    // Strobes are registered alongside the state, so they track state exactly.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_state <= ST_IDLE;
            r_size  <= SZ_BYTE;
            r_off   <= 2'b00;
            r_sext  <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_rd_n  <= 1'b1;
            r_wr_n  <= 1'b1;
            r_daddr <= '0;
            r_dout  <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req) begin
                        r_size  <= size;
                        r_off   <= addr[1:0];
                        r_sext  <= sign_ext;
                        r_wdata <= wdata;
                        r_daddr <= w_base;
                        r_busy  <= 1'b1;
                        if (w_bad) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else if (!we) begin
                            r_state <= ST_RD;
                            r_rd_n  <= 1'b0;
                        end else if (size == SZ_WORD) begin
                            r_state <= ST_WR;
                            r_wr_n  <= 1'b0;
                            r_dout  <= wdata;
                        end else begin
                            r_state <= ST_RMW_RD;
                            r_rd_n  <= 1'b0;
                        end
                    end
                end
                ST_RD: begin
                    r_rdata <= w_ext;
                    r_rd_n  <= 1'b1;
                    r_done  <= 1'b1;
                    r_state <= ST_DONE;
                end
                ST_RMW_RD: begin
                    r_dout  <= w_merge;
                    r_rd_n  <= 1'b1;
                    r_wr_n  <= 1'b0;
                    r_state <= ST_WR;
                end
                ST_WR: begin
                    r_wr_n  <= 1'b1;
                    r_done  <= 1'b1;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_rd_n  <= 1'b1;
                    r_wr_n  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rdata      = r_rdata;
    assign done       = r_done;
    assign err        = r_err;
    assign busy       = r_busy;
    assign mem_RD     = r_rd_n;
    assign mem_WR     = r_wr_n;
    assign mem_Daddr  = r_daddr;
    assign mem_DataIn = r_dout;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed plan cases plus random accesses checked
// against a byte-array memory model.
module tb_mem_access_unit;

    localparam int unsigned MEM_BYTES = 61;

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sign_ext = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        done;
    logic        err;
    logic        busy;
    logic        mem_RD;
    logic        mem_WR;
    logic [31:0] mem_Daddr;
    logic [31:0] mem_DataIn;
    logic [31:0] mem_DataOut;

    logic [7:0]  ram  [0:63];
    logic [7:0]  refm [0:63];
    logic [31:0] exp_rdata = '0;
    int          n_vec = 0;
    int          n_miss = 0;

    mem_access_unit #(.MEM_BYTES(MEM_BYTES)) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .req         (req),
        .we          (we),
        .size        (size),
        .sign_ext    (sign_ext),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .done        (done),
        .err         (err),
        .busy        (busy),
        .mem_RD      (mem_RD),
        .mem_WR      (mem_WR),
        .mem_Daddr   (mem_Daddr),
        .mem_DataIn  (mem_DataIn),
        .mem_DataOut (mem_DataOut)
    );

    always #5 CLK = ~CLK;

    always_comb begin
        if (mem_Daddr <= 32'd60)
            mem_DataOut = {ram[mem_Daddr], ram[mem_Daddr + 1], ram[mem_Daddr + 2], ram[mem_Daddr + 3]};
        else
            mem_DataOut = 32'hDEAD_BEEF;
    end

    // Memory commits on the falling edge inside the write strobe.
    always @(negedge CLK) begin
        if (mem_WR === 1'b0 && mem_Daddr <= 32'd60) begin
            ram[mem_Daddr]     = mem_DataIn[31:24];
            ram[mem_Daddr + 1] = mem_DataIn[23:16];
            ram[mem_Daddr + 2] = mem_DataIn[15:8];
            ram[mem_Daddr + 3] = mem_DataIn[7:0];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ram_word(input int a);
        return {ram[a], ram[a + 1], ram[a + 2], ram[a + 3]};
    endfunction

    function automatic logic model_bad(input logic [1:0] sz, input logic [31:0] a);
        longint base;
        base = longint'(a) - longint'(a % 4);
        return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0)
            || (base + 3 > longint'(MEM_BYTES) - 1);
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sx, input int a);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = 32'(refm[a]);
            if (sx && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = 32'(refm[a]) * 256 + 32'(refm[a + 1]);
            if (sx && v >= 32'd32768) v = v + 32'hFFFF_0000;
        end else begin
            v = {refm[a], refm[a + 1], refm[a + 2], refm[a + 3]};
        end
        return v;
    endfunction

    task automatic model_store(input logic [1:0] sz, input int a, input logic [31:0] d);
        int n;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        for (int k = 0; k < n; k++)
            refm[a + k] = 8'(d >> (8 * (n - 1 - k)));
    endtask

    task automatic access(input string tag, input logic w, input logic [1:0] sz,
                          input logic sx, input logic [31:0] a, input logic [31:0] d);
        logic bad;
        int   lat_exp, rd_exp, wr_exp;
        int   n, rdc, wrc, both, busy_low;
        logic got_done, got_err;
        logic [31:0] ld_val;
        bad = model_bad(sz, a);
        if (bad) begin lat_exp = 1; rd_exp = 0; wr_exp = 0; end
        else if (!w) begin lat_exp = 2; rd_exp = 1; wr_exp = 0; end
        else if (sz == 2'd2) begin lat_exp = 2; rd_exp = 0; wr_exp = 1; end
        else begin lat_exp = 3; rd_exp = 1; wr_exp = 1; end
        ld_val = (!bad && !w) ? model_load(sz, sx, int'(a)) : 32'h0;

        @(negedge CLK);
        req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = d;
        @(posedge CLK);
        #1;
        // Junk on the inputs while busy must be ignored.
        req = 1'($urandom); we = 1'($urandom); size = 2'($urandom);
        sign_ext = 1'($urandom); addr = $urandom; wdata = $urandom;
        n = 0; rdc = 0; wrc = 0; both = 0; busy_low = 0; got_done = 1'b0; got_err = 1'b0;
        while (!got_done && n < 8) begin
            @(negedge CLK);
            n++;
            if (mem_RD === 1'b0) rdc++;
            if (mem_WR === 1'b0) wrc++;
            if (mem_RD === 1'b0 && mem_WR === 1'b0) both++;
            if (busy !== 1'b1) busy_low++;
            if (done === 1'b1) begin
                got_done = 1'b1;
                got_err  = err;
                req = 1'b0;
            end
        end
        req = 1'b0;
        check({tag, "_latency"}, 32'(got_done ? n : 99), 32'(lat_exp));
        check({tag, "_err"}, 32'(got_err), 32'(bad));
        check({tag, "_rd_cycles"}, 32'(rdc), 32'(rd_exp));
        check({tag, "_wr_cycles"}, 32'(wrc), 32'(wr_exp));
        check({tag, "_both_low"}, 32'(both), 32'd0);
        check({tag, "_busy"}, 32'(busy_low), 32'd0);
        if (!bad && !w) exp_rdata = ld_val;
        if (!bad && w) model_store(sz, int'(a), d);
        @(negedge CLK);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_busy_idle"}, 32'(busy), 32'd0);
        check({tag, "_rdata"}, rdata, exp_rdata);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rdata"}, rdata, 32'h0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_mem_RD"}, 32'(mem_RD), 32'd1);
        check({tag, "_mem_WR"}, 32'(mem_WR), 32'd1);
        check({tag, "_Daddr"}, mem_Daddr, 32'h0);
        check({tag, "_DataIn"}, mem_DataIn, 32'h0);
    endtask

    initial begin
        logic [31:0] a;
        for (int i = 0; i < 64; i++) begin
            ram[i]  = 8'($urandom);
            refm[i] = ram[i];
        end

        #12;
        check_reset_values("reset");
        @(negedge CLK);
        Reset = 1'b1;

        access("sw8", 1'b1, 2'd2, 1'b0, 32'd8, 32'h1122_3344);
        check("sw8_ram", ram_word(8), 32'h1122_3344);
        access("lw8", 1'b0, 2'd2, 1'b0, 32'd8, 32'h0);
        check("lw8_const", rdata, 32'h1122_3344);

        access("sw12", 1'b1, 2'd2, 1'b0, 32'd12, 32'h80FF_7F01);
        access("lb13", 1'b0, 2'd0, 1'b1, 32'd13, 32'h0);
        check("lb13_const", rdata, 32'hFFFF_FFFF);
        access("lbu12", 1'b0, 2'd0, 1'b0, 32'd12, 32'h0);
        check("lbu12_const", rdata, 32'h0000_0080);
        access("lb14", 1'b0, 2'd0, 1'b1, 32'd14, 32'h0);
        check("lb14_const", rdata, 32'h0000_007F);
        access("lh12s", 1'b0, 2'd1, 1'b1, 32'd12, 32'h0);
        access("lhu14", 1'b0, 2'd1, 1'b0, 32'd14, 32'h0);

        access("sw16", 1'b1, 2'd2, 1'b0, 32'd16, 32'hAABB_CCDD);
        access("sb18", 1'b1, 2'd0, 1'b0, 32'd18, 32'h1234_5699);
        check("sb18_ram", ram_word(16), 32'hAABB_99DD);
        access("sh16", 1'b1, 2'd1, 1'b0, 32'd16, 32'hCAFE_5A5A);
        check("sh16_ram", ram_word(16), 32'h5A5A_99DD);

        access("err_lh5", 1'b0, 2'd1, 1'b0, 32'd5, 32'h0);
        access("err_sw6", 1'b1, 2'd2, 1'b0, 32'd6, 32'hFFFF_FFFF);
        access("err_sz3", 1'b0, 2'd3, 1'b0, 32'd20, 32'h0);
        access("err_lw60", 1'b0, 2'd2, 1'b0, 32'd60, 32'h0);
        access("ok_lw56", 1'b0, 2'd2, 1'b0, 32'd56, 32'h0);

        // Asynchronous reset in the WR cycle of a halfword store, before its negedge.
        refm[24] = 8'h01; refm[25] = 8'h02; refm[26] = 8'h03; refm[27] = 8'h04;
        ram[24]  = 8'h01; ram[25]  = 8'h02; ram[26]  = 8'h03; ram[27]  = 8'h04;
        @(negedge CLK);
        req = 1'b1; we = 1'b1; size = 2'd1; sign_ext = 1'b0; addr = 32'd26; wdata = 32'h0000_BEEF;
        @(posedge CLK);
        #1 req = 1'b0;
        @(posedge CLK);
        #1;
        check("rst_in_wr_strobe", 32'(mem_WR), 32'd0);
        Reset = 1'b0;
        #1;
        check_reset_values("rst_mid");
        @(negedge CLK);
        #1;
        check("rst_no_write", ram_word(24), 32'h0102_0304);
        @(negedge CLK);
        Reset = 1'b1;
        exp_rdata = 32'h0;
        access("lw24_after_rst", 1'b0, 2'd2, 1'b0, 32'd24, 32'h0);
        check("lw24_const", rdata, 32'h0102_0304);

        for (int i = 0; i < 80; i++) begin
            a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 63));
            access("rand", 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
        end

        for (int i = 0; i < 64; i += 4)
            check("final_mem", ram_word(i), {refm[i], refm[i + 1], refm[i + 2], refm[i + 3]});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store sequencer between the multi-cycle CPU control/ALU path and the byte-addressed, big-endian data memory. The data memory only transfers whole 32-bit words through active-low read and write strobes. This unit therefore does four things: word-aligns the address, extracts and extends byte and halfword loads, performs read-modify-write for byte and halfword stores, and flags misaligned or out-of-range accesses. It sits directly upstream of the data memory, and its captured load result feeds the CPU data register.

## Interface
Parameters:
- MEM_BYTES, 61: number of implemented memory bytes (0..MEM_BYTES-1); bounds check only.

Ports:
- CLK  in  1  clock; all state changes on posedge.
- Reset  in  1  asynchronous, active-low reset.
- req  in  1  access request; sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr  in  32  byte address.
- wdata  in  32  store data, right-justified for byte and half.
- rdata  out  32  load result, held until the next successful load completes.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; 1 = misaligned, illegal size or out of range, no memory access made.
- busy  out  1  high from the cycle after acceptance through the DONE cycle.
- mem_RD  out  1  active-low read strobe to memory.
- mem_WR  out  1  active-low write strobe to memory; memory writes on the negedge inside the strobe cycle.
- mem_Daddr  out  32  word address, addr with bits [1:0] cleared.
- mem_DataIn  out  32  write word to memory.
- mem_DataOut  in  32  combinational read word from memory.

## Operation
- States: IDLE, RD, RMW_RD, WR, DONE.
- IDLE
  - When req=1, latch addr, wdata, size, we and sign_ext.
  - Check the access:
    - half with addr[0]=1 is illegal;
    - word with addr[1:0]≠0 is illegal;
    - size=11 is illegal;
    - addr[1:0]-cleared word base + 3 > MEM_BYTES-1 is out of range.
  - Next state:
    - any check failing → DONE with err=1;
    - load → RD;
    - word store → WR;
    - byte or half store → RMW_RD.
- RD: mem_RD=0. At posedge, capture the extracted lane into rdata, then → DONE.
- RMW_RD: mem_RD=0. At posedge, form the merge word from mem_DataOut with the target lane(s) replaced by wdata low bits, place it on mem_DataIn, then → WR.
- WR: mem_WR=0 for exactly one cycle, then → DONE.
- DONE: done=1, err as latched, then → IDLE.
- Lanes are big-endian:
  - byte offset 0 = [31:24], 1 = [23:16], 2 = [15:8], 3 = [7:0];
  - half offset 0 = [31:16], 2 = [15:0].
- Extension: sign_ext replicates the lane MSB to bit 31; otherwise upper bits are 0. Word loads ignore sign_ext.
- mem_RD and mem_WR are Moore-decoded from state only, never from req. They are never both low.
- req is ignored while busy; no queuing.

## Timing
- Reset values:
  - IDLE;
  - rdata=0, done=0, err=0, busy=0;
  - mem_RD=1, mem_WR=1;
  - mem_Daddr=0, mem_DataIn=0.
- Latency from the accepting posedge (cycle 0) to the done cycle:
  - load: 2 (RD in cycle 1, done in cycle 2);
  - word store: 2;
  - byte or half store: 3;
  - error: 1.
- Back-to-back requests: the next req can be accepted in the cycle after DONE, so one access completes every 3 or 4 cycles.
- mem_Daddr and mem_DataIn are stable for the whole strobe cycle, including the negedge write point.
- Asynchronous reset mid-operation:
  - strobes go high immediately and the state returns to IDLE;
  - a WR cycle interrupted before its negedge performs no write;
  - rdata is cleared.

## Structure
- Shared package mem_pkg holds:
  - the size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - the state enum;
  - the lane-select helper constants.
- One sub-module, mem_lane_extract: combinational lane select and sign/zero extension.
- Store merge and the bounds check stay inline.

## Test plan
- Word store then load:
  - stimulus: store addr=8, wdata=0x11223344, then load word at 8;
  - required: ram[8..11]=11,22,33,44; rdata=0x11223344; done 2 cycles after each accept.
- Byte load with sign and zero extension:
  - setup: memory word at 12 = 0x80FF7F01;
  - lb addr=13 sign_ext=1 → rdata=0xFFFFFFFF;
  - lbu addr=12 → rdata=0x00000080;
  - lb addr=14 sign_ext=1 → rdata=0x0000007F.
- Byte store read-modify-write:
  - stimulus: word at 16 = 0xAABBCCDD, sb addr=18 wdata=0x12345699;
  - required: word becomes 0xAABB99DD; RMW_RD then WR strobes seen; done on cycle 3.
- Error cases, all requiring err=1 on cycle 1 with mem_RD and mem_WR never low:
  - half load at addr=5;
  - word store at addr=6;
  - size=11;
  - word load at addr=60 with MEM_BYTES=61.
- Reset during a write: a sub-word store is in progress, and Reset is asserted during the WR cycle before its negedge → the memory word is unchanged, all outputs are at reset values, and a following load completes normally.
